// File: rtl/sample_scheduler.sv
// Monte Carlo pi-estimate sequencer: clears the pixel image, then writes
// accepted LFSR samples and counts total and inside-circle hits.
module sample_scheduler #(
    parameter int X_MAX     = 480,
    parameter int Y_MAX     = 480,
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             sample_valid_i,
    input  logic [8:0]       sample_x_i,
    input  logic [8:0]       sample_y_i,
    input  logic             sample_inside_i,
    output logic             wr_en_o,
    output logic [9:0]       wr_x_o,
    output logic [9:0]       wr_y_o,
    output logic             wr_color_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] total_cnt_o,
    output logic [CNT_W-1:0] inside_cnt_o
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [9:0]       X_LIM    = 10'(X_MAX);
    localparam logic [9:0]       Y_LIM    = 10'(Y_MAX);
    localparam logic [9:0]       X_LAST   = 10'(X_MAX - 1);
    localparam logic [9:0]       Y_LAST   = 10'(Y_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             wr_en_q, wr_en_d;
    logic [9:0]       wr_x_q, wr_x_d;
    logic [9:0]       wr_y_q, wr_y_d;
    logic             wr_color_q, wr_color_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] inside_q, inside_d;

    logic [9:0] sampleX, sampleY;
    logic       accept;
    logic       lastClear;

    assign sampleX   = {1'b0, sample_x_i};
    assign sampleY   = {1'b0, sample_y_i};
    assign accept    = sample_valid_i && (sampleX < X_LIM) && (sampleY < Y_LIM);
    assign lastClear = (wr_x_q == X_LAST) && (wr_y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        busy_d     = busy_q;
        done_d     = done_q;
        total_d    = total_q;
        inside_d   = inside_q;

        if (abort_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // The first clear write is already presented on the start edge.
                    if (start_i) begin
                        state_d    = CLEAR;
                        wr_en_d    = 1'b1;
                        wr_x_d     = '0;
                        wr_y_d     = '0;
                        wr_color_d = 1'b0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        total_d    = '0;
                        inside_d   = '0;
                    end
                end
                CLEAR: begin
                    if (lastClear) begin
                        state_d = RUN;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_color_d = 1'b0;
                        if (wr_x_q == X_LAST) begin
                            wr_x_d = '0;
                            wr_y_d = wr_y_q + 10'd1;
                        end else begin
                            wr_x_d = wr_x_q + 10'd1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_en_d    = 1'b1;
                        wr_x_d     = sampleX;
                        wr_y_d     = sampleY;
                        wr_color_d = 1'b1;
                        total_d    = total_q + CNT_ONE;
                        inside_d   = inside_q + {{(CNT_W-1){1'b0}}, sample_inside_i};
                        if (total_q == CNT_LAST) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_color_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            total_q    <= '0;
            inside_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            total_q    <= total_d;
            inside_q   <= inside_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_x_o       = wr_x_q;
    assign wr_y_o       = wr_y_q;
    assign wr_color_o   = wr_color_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign total_cnt_o  = total_q;
    assign inside_cnt_o = inside_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Scoreboard bench for sample_scheduler on a reduced 40x30 image with a
// 4-sample run so clear sweeps and run completion stay short.
module tb_sample_scheduler;

    localparam int XM = 40;
    localparam int YM = 30;
    localparam int NS = 4;
    localparam int CW = 17;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       c;
    } expWr_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start, abort, sampleValid, sampleInside;
    logic [8:0]    sampleX, sampleY;
    logic          wrEn, wrColor, busy, done;
    logic [9:0]    wrX, wrY;
    logic [CW-1:0] totalCnt, insideCnt;

    expWr_t expQ[$];
    int     checks = 0;
    int     errors = 0;
    int     writeCount = 0;

    sample_scheduler #(
        .X_MAX(XM), .Y_MAX(YM), .N_SAMPLES(NS), .CNT_W(CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .abort_i        (abort),
        .sample_valid_i (sampleValid),
        .sample_x_i     (sampleX),
        .sample_y_i     (sampleY),
        .sample_inside_i(sampleInside),
        .wr_en_o        (wrEn),
        .wr_x_o         (wrX),
        .wr_y_o         (wrY),
        .wr_color_o     (wrColor),
        .busy_o         (busy),
        .done_o         (done),
        .total_cnt_o    (totalCnt),
        .inside_cnt_o   (insideCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int x, input int y, input logic ins,
                                 input logic st, input logic ab);
        sampleValid  = v;
        sampleX      = 9'(x);
        sampleY      = 9'(y);
        sampleInside = ins;
        start        = st;
        abort        = ab;
        stepCycle();
    endtask

    task automatic pushWrite(input int x, input int y, input logic c);
        expWr_t e;
        e.x = 10'(x);
        e.y = 10'(y);
        e.c = c;
        expQ.push_back(e);
    endtask

    task automatic pushClear();
        for (int y = 0; y < YM; y++)
            for (int x = 0; x < XM; x++)
                pushWrite(x, y, 1'b0);
    endtask

    task automatic waitClearEnd();
        int n = 0;
        while (wrEn && n < XM * YM + 50) begin
            stepCycle();
            n++;
        end
        checkOutput("clear_ends_in_budget", 32'(wrEn), 32'd0);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rstN && wrEn) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write_x", 32'(wrX), 32'hFFFF_FFFF);
            end else begin
                expWr_t e;
                e = expQ.pop_front();
                checkOutput("write_x", 32'(wrX), 32'(e.x));
                checkOutput("write_y", 32'(wrY), 32'(e.y));
                checkOutput("write_color", 32'(wrColor), 32'(e.c));
            end
        end
    end

    initial begin
        int n;
        rstN = 1'b0;
        sampleValid = 1'b0; sampleX = '0; sampleY = '0; sampleInside = 1'b0;
        start = 1'b0; abort = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_wr_en", 32'(wrEn), 32'd0);
        checkOutput("reset_wr_x", 32'(wrX), 32'd0);
        checkOutput("reset_wr_y", 32'(wrY), 32'd0);
        checkOutput("reset_color", 32'(wrColor), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_total", 32'(totalCnt), 32'd0);
        checkOutput("reset_inside", 32'(insideCnt), 32'd0);
        rstN = 1'b1;
        stepCycle();

        // Full clear sweep, with samples offered early on that must be ignored
        pushClear();
        writeCount = 0;
        applyStimulus(1'b1, 3, 3, 1'b1, 1'b1, 1'b0);
        checkOutput("clear_first_wr_en", 32'(wrEn), 32'd1);
        checkOutput("clear_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3, 3, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        waitClearEnd();
        checkOutput("clear_write_count", 32'(writeCount), 32'(XM * YM));
        checkOutput("clear_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("clear_last_x", 32'(wrX), 32'(XM - 1));
        checkOutput("clear_last_y", 32'(wrY), 32'(YM - 1));
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_done", 32'(done), 32'd0);
        checkOutput("run_total_zero", 32'(totalCnt), 32'd0);

        // Accepted sample, then out-of-range rejects, then corner accept
        pushWrite(10, 20, 1'b1);
        applyStimulus(1'b1, 10, 20, 1'b1, 1'b0, 1'b0);
        checkOutput("acc1_wr_en", 32'(wrEn), 32'd1);
        checkOutput("acc1_total", 32'(totalCnt), 32'd1);
        checkOutput("acc1_inside", 32'(insideCnt), 32'd1);
        applyStimulus(1'b1, XM, 10, 1'b1, 1'b0, 1'b0);
        checkOutput("rej_x_wr_en", 32'(wrEn), 32'd0);
        applyStimulus(1'b1, 10, 511, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("rej_total", 32'(totalCnt), 32'd1);
        checkOutput("rej_inside", 32'(insideCnt), 32'd1);
        checkOutput("rej_hold_x", 32'(wrX), 32'd10);
        checkOutput("rej_hold_y", 32'(wrY), 32'd20);
        pushWrite(XM - 1, YM - 1, 1'b1);
        applyStimulus(1'b1, XM - 1, YM - 1, 1'b0, 1'b0, 1'b0);
        checkOutput("acc2_total", 32'(totalCnt), 32'd2);
        checkOutput("acc2_inside", 32'(insideCnt), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Abort beats start, coincident sample dropped
        applyStimulus(1'b1, 5, 5, 1'b1, 1'b1, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_wr_en", 32'(wrEn), 32'd0);
        checkOutput("abort_total", 32'(totalCnt), 32'd2);
        checkOutput("abort_inside", 32'(insideCnt), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Restart, then run to completion with six back-to-back samples
        pushClear();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("restart_total_zero", 32'(totalCnt), 32'd0);
        checkOutput("restart_inside_zero", 32'(insideCnt), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        waitClearEnd();
        pushWrite(0, 0, 1'b1);
        pushWrite(1, 2, 1'b1);
        pushWrite(3, 4, 1'b1);
        pushWrite(5, 6, 1'b1);
        applyStimulus(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("n3_total", 32'(totalCnt), 32'd3);
        checkOutput("n3_done", 32'(done), 32'd0);
        applyStimulus(1'b1, 5, 6, 1'b1, 1'b0, 1'b0);
        checkOutput("n4_total", 32'(totalCnt), 32'd4);
        checkOutput("n4_inside", 32'(insideCnt), 32'd3);
        checkOutput("n4_done", 32'(done), 32'd1);
        checkOutput("n4_busy", 32'(busy), 32'd0);
        checkOutput("n4_wr_en", 32'(wrEn), 32'd1);
        applyStimulus(1'b1, 7, 8, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9, 9, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_total_hold", 32'(totalCnt), 32'd4);
        checkOutput("done_inside_hold", 32'(insideCnt), 32'd3);
        checkOutput("done_stays", 32'(done), 32'd1);
        checkOutput("done_queue_empty", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_abort", 32'(done), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-clear, then a fresh sweep from (0,0)
        pushClear();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(wrX == 10'd37 && wrY == 10'd12) && n < XM * YM) begin
            stepCycle();
            n++;
        end
        checkOutput("reach_37_12", 32'(wrX == 10'd37 && wrY == 10'd12), 32'd1);
        #2;
        rstN = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_wr_en", 32'(wrEn), 32'd0);
        checkOutput("async_wr_x", 32'(wrX), 32'd0);
        checkOutput("async_wr_y", 32'(wrY), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_total", 32'(totalCnt), 32'd0);
        repeat (2) stepCycle();
        rstN = 1'b1;
        stepCycle();
        pushClear();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("reclear_x0", 32'(wrX), 32'd0);
        checkOutput("reclear_y0", 32'(wrY), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        waitClearEnd();
        checkOutput("reclear_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("reclear_busy", 32'(busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
